// File: rtl/drive_cmd_encoder.sv
`default_nettype none
// ============================================================================
// drive_cmd_encoder : synchronised, debounced and arbitrated direction command bus
// Rev 1.0
// ============================================================================
module drive_cmd_encoder #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_now,
  input  logic [3:0] state,
  input  logic       sw_left,
  input  logic       sw_right,
  input  logic       sw_back,
  input  logic       sw_forward,
  output logic [3:0] answer,
  output logic       conflict,
  output logic       cmd_change
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam int IDX_FWD   = 0;
  localparam int IDX_BACK  = 1;
  localparam int IDX_RIGHT = 2;
  localparam int IDX_LEFT  = 3;

  localparam logic [3:0] ST_STARTING = 4'b0010;
  localparam logic [3:0] ST_MOVING   = 4'b0100;

  // Channel order matches the answer bit positions.
  logic [3:0] raw;
  logic [3:0] stable;

  assign raw = {sw_left, sw_right, sw_back, sw_forward};

  for (genvar gi = 0; gi < 4; gi++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   stable_q;
    logic                   stable_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q   <= '0;
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        sync_q   <= {sync_q[SYNC_STAGES-2:0], raw[gi]};
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    // Counter only runs while the synced level disagrees with the accepted one,
    // so it is cleared on acceptance and can never pass CNT_MAX.
    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (synced != stable_q) begin
        if (cnt_q == CNT_MAX) begin
          stable_d = synced;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    assign stable[gi] = stable_q;
  end

  logic       turn_l;
  logic       turn_r;
  logic       move_f;
  logic       move_b;
  logic       turn_ok;
  logic       move_ok;
  logic [3:0] answer_d;
  logic [3:0] answer_q;
  logic       conflict_d;
  logic       conflict_q;
  logic       cmd_change_d;
  logic       cmd_change_q;

  always_comb begin
    turn_l  = stable[IDX_LEFT]  & ~stable[IDX_RIGHT];
    turn_r  = stable[IDX_RIGHT] & ~stable[IDX_LEFT];
    move_f  = stable[IDX_FWD]   & ~stable[IDX_BACK];
    move_b  = stable[IDX_BACK]  & ~stable[IDX_FWD];
    turn_ok = (state == ST_STARTING) || (state == ST_MOVING);
    move_ok = (state == ST_MOVING);

    answer_d = {turn_l & turn_ok, turn_r & turn_ok, move_b & move_ok, move_f & move_ok};
    if (power_now) begin
      answer_d = 4'b0000;
    end

    // Conflict reports raw opposing requests regardless of car state.
    conflict_d = ~power_now &
                 ((stable[IDX_LEFT] & stable[IDX_RIGHT]) |
                  (stable[IDX_FWD]  & stable[IDX_BACK]));

    cmd_change_d = (answer_d != answer_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      answer_q     <= 4'b0000;
      conflict_q   <= 1'b0;
      cmd_change_q <= 1'b0;
    end else begin
      answer_q     <= answer_d;
      conflict_q   <= conflict_d;
      cmd_change_q <= cmd_change_d;
    end
  end

  assign answer     = answer_q;
  assign conflict   = conflict_q;
  assign cmd_change = cmd_change_q;

endmodule
`default_nettype wire
